gbsha_fir_sched: RTL and testbench

//   Sequencer for a time-shared FIR datapath: one external signed multiplier serves all N_TAPS taps.

---
 rtl/gbsha_fir_sched.sv | 112 +++++++++++
 tb/tb_gbsha_fir_sched.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gbsha_fir_sched.sv
// Sequencer for a time-shared FIR: serial coefficient load, delay-line shift per sample,
// N_TAPS multiply-accumulate cycles through one external multiplier, then a valid/ready result.
module gbsha_fir_sched #(
  parameter int N_TAPS     = 4,
  parameter int BW_in      = 6,
  parameter int BW_product = 12,
  parameter int BW_acc     = 14,
  parameter int BW_out     = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [BW_in-1:0]      x_in,
  output logic signed [BW_in-1:0]      mul_a,
  output logic signed [BW_in-1:0]      mul_b,
  input  logic signed [BW_product-1:0] mul_p,
  output logic                         y_valid,
  input  logic                         y_ready,
  output logic        [BW_out-1:0]     y_out
);

  localparam int TAP_W = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
  localparam logic [TAP_W-1:0] LAST = TAP_W'(N_TAPS - 1);

  typedef enum logic [1:0] {S_LOAD, S_IDLE, S_MAC, S_OUT} state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic [TAP_W-1:0]         r_k;
  logic [TAP_W-1:0]         r_tap;
  logic signed [BW_in-1:0]  r_coeff [N_TAPS];
  logic signed [BW_in-1:0]  r_x     [N_TAPS];
  logic signed [BW_acc-1:0] r_acc;
  logic [BW_acc-1:0]        w_acc_sum;
  logic [BW_out-1:0]        r_y_out;
  logic                     w_in_xfer;
  logic                     w_y_xfer;

  assign w_in_xfer = in_valid && in_ready;
  assign w_y_xfer  = y_valid && y_ready;
  assign y_out     = r_y_out;

  // Accumulator wraps modulo 2^BW_acc; the product is sign-extended explicitly.
  assign w_acc_sum = r_acc + {{(BW_acc - BW_product){mul_p[BW_product-1]}}, mul_p};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_LOAD;
    else          r_state <= w_next;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LOAD:  if (w_in_xfer && (r_k == LAST)) w_next = S_IDLE;
      S_IDLE:  if (w_in_xfer)                  w_next = S_MAC;
      S_MAC:   if (r_tap == LAST)              w_next = S_OUT;
      S_OUT:   if (w_y_xfer)                   w_next = S_IDLE;
      default:                                 w_next = S_LOAD;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    y_valid  = 1'b0;
    mul_a    = '0;
    mul_b    = '0;
    case (r_state)
      S_LOAD, S_IDLE: in_ready = 1'b1;
      S_MAC: begin
        mul_a = r_x[r_tap];
        mul_b = r_coeff[r_tap];
      end
      S_OUT:   y_valid = 1'b1;
      default: ;
    endcase
  end

  // NOTE: coefficient and delay-line arrays are reset because a reset must clear stale history.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_k     <= '0;
      r_tap   <= '0;
      r_acc   <= '0;
      r_y_out <= '0;
      for (int i = 0; i < N_TAPS; i++) begin
        r_coeff[i] <= '0;
        r_x[i]     <= '0;
      end
    end else begin
      if ((r_state == S_LOAD) && w_in_xfer) begin
        r_coeff[r_k] <= x_in;
        r_k          <= r_k + 1'b1;
      end
      if ((r_state == S_IDLE) && w_in_xfer) begin
        r_x[0] <= x_in;
        for (int i = 1; i < N_TAPS; i++) r_x[i] <= r_x[i-1];
        r_acc <= '0;
        r_tap <= '0;
      end
      if (r_state == S_MAC) begin
        r_acc <= w_acc_sum;
        r_tap <= (r_tap == LAST) ? '0 : r_tap + 1'b1;
        // y_out is captured once so it stays put through OUT and afterwards.
        if (r_tap == LAST) r_y_out <= w_acc_sum[BW_out-1:0];
      end
    end
  end

endmodule

// File: tb/tb_gbsha_fir_sched.sv
// Bench for gbsha_fir_sched: behavioural multiplier, reference FIR model and a result scoreboard.
module tb_gbsha_fir_sched;

  localparam int N = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              in_valid;
  logic              in_ready;
  logic signed [5:0] x_in;
  logic signed [5:0] mul_a;
  logic signed [5:0] mul_b;
  logic signed [11:0] mul_p;
  logic              y_valid;
  logic              y_ready;
  logic [7:0]        y_out;

  gbsha_fir_sched #(.N_TAPS(4), .BW_in(6), .BW_product(12), .BW_acc(14), .BW_out(8)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p), .y_valid(y_valid), .y_ready(y_ready),
    .y_out(y_out)
  );

  always #5 clk = ~clk;
  assign mul_p = mul_a * mul_b;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         m_coeff [N];
  int         m_x     [N];
  int         m_k      = 0;
  int         mac_tap  = -1;
  int         prev_acc = -1;
  bit         check_tp = 0;
  logic [7:0] exp_q [$];

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_coeff[i] = 0;
      m_x[i]     = 0;
    end
    m_k      = 0;
    mac_tap  = -1;
    prev_acc = -1;
    exp_q.delete();
  endtask

  task automatic model_sample(input int v);
    int         sum;
    logic [13:0] a14;
    logic [7:0]  y;
    for (int i = N - 1; i > 0; i--) m_x[i] = m_x[i-1];
    m_x[0] = v;
    sum = 0;
    for (int i = 0; i < N; i++) sum += m_coeff[i] * m_x[i];
    a14 = 14'(sum);
    y   = a14[7:0];
    exp_q.push_back(y);
    mac_tap = 0;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push_in(input int v, input bit is_sample);
    bit ok = 0;
    in_valid = 1'b1;
    x_in     = 6'(v);
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("in_accept", 32'(ok), 32'd1);
    if (ok) begin
      if (is_sample) begin
        if (check_tp && prev_acc >= 0) check("throughput", 32'(cyc - prev_acc), 32'd6);
        prev_acc = cyc;
        model_sample(v);
      end else begin
        m_coeff[m_k] = v;
        m_k++;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(posedge clk);
      #1;
      done = (exp_q.size() == 0) && (mac_tap < 0) && in_ready;
    end
    check("drain_timeout", 32'(done), 32'd1);
  endtask

  task automatic apply_reset(input int edges);
    reset_n = 1'b0;
    model_clear();
    idle(edges);
    reset_n = 1'b1;
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_y_valid"},  32'(y_valid),  32'd0);
    check({tag, "_mul_a"},    32'(mul_a),    32'd0);
    check({tag, "_mul_b"},    32'(mul_b),    32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic load4(input int c0, input int c1, input int c2, input int c3);
    push_in(c0, 0);
    push_in(c1, 0);
    push_in(c2, 0);
    push_in(c3, 0);
  endtask

  // Per-cycle MAC operand / latency checks and scoreboard pop.
  always @(negedge clk) begin
    if (mac_tap >= 0) begin
      if (mac_tap < N) begin
        check("mac_mul_a",    32'(mul_a),    32'(m_x[mac_tap]));
        check("mac_mul_b",    32'(mul_b),    32'(m_coeff[mac_tap]));
        check("mac_in_ready", 32'(in_ready), 32'd0);
        check("mac_y_valid",  32'(y_valid),  32'd0);
        mac_tap++;
      end else begin
        check("latency_y_valid", 32'(y_valid), 32'd1);
        mac_tap = -1;
      end
    end
    if (y_valid && y_ready) begin
      if (exp_q.size() == 0) check("unexpected_y", 32'd1, 32'd0);
      else                   check("y_out", 32'(y_out), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] held;
    bit         seen;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    x_in     = '0;
    y_ready  = 1'b1;
    model_clear();
    idle(2);
    @(negedge clk);
    check("rst_y_out", 32'(y_out), 32'd0);
    reset_n = 1'b1;
    idle(1);
    check_reset_state("rst");

    // Impulse response with back-to-back samples at full throughput.
    load4(1, 2, 3, 4);
    check_tp = 1;
    foreach (m_coeff[i]) ;
    push_in(1, 1); push_in(0, 1); push_in(0, 1); push_in(0, 1); push_in(0, 1);
    check_tp = 0;
    wait_drain();

    // Consumer stall in OUT, with an offered sample that must wait for IDLE.
    y_ready = 1'b0;
    push_in(7, 1);
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = y_valid;
    end
    check("stall_y_valid_seen", 32'(seen), 32'd1);
    held = y_out;
    check("stall_y_out_value", 32'(held), 32'd7);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    x_in     = 6'sd9;
    repeat (5) begin
      @(negedge clk);
      check("stall_y_valid",  32'(y_valid),  32'd1);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_y_out",    32'(y_out),    32'(held));
    end
    @(posedge clk);
    #1;
    y_ready = 1'b1;
    push_in(9, 1);
    wait_drain();

    // Sign extension and truncation: 31 * -32 accumulated over four taps.
    apply_reset(1);
    check_reset_state("rst2");
    load4(31, 31, 31, 31);
    push_in(-32, 1); push_in(-32, 1); push_in(-32, 1); push_in(-32, 1);
    wait_drain();

    // Coefficient load with gaps in in_valid.
    apply_reset(2);
    push_in(1, 0);
    idle(1);
    push_in(2, 0);
    idle(2);
    push_in(3, 0);
    push_in(4, 0);
    push_in(1, 1); push_in(0, 1); push_in(0, 1); push_in(0, 1);
    wait_drain();

    // Reset on the second MAC cycle discards the result and clears the delay line.
    push_in(5, 1);
    idle(1);
    apply_reset(1);
    check_reset_state("rst_mid_mac");
    load4(5, 5, 5, 5);
    push_in(1, 1); push_in(0, 1); push_in(0, 1); push_in(0, 1);
    wait_drain();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
